uart_rx_core: RTL and testbench

Serial receive engine of the UART peripheral. It sits directly upstream of the bus-side register/FIFO logic that the sif/apb/ahb/avalon front-ends expose. It synchronises the rx line and detects start bits, then samples data, optional parity and 1 or 2 stop bits at mid-bit. Each received byte is presented with its error flags on a valid/ready handshake to the register stage.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_core_if.sv | 22 ++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx_core.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and divider floor.
package uart_pkg;

  localparam int UART_MIN_DIV = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2,
    RX_WAIT_HI
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_core_if.sv
// Valid/ready handoff of a received byte and its error flags to the register stage.
interface uart_rx_core_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_perr;
  logic              rx_ferr;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output rx_data, rx_perr, rx_ferr, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_perr, rx_ferr, rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the serial line plus falling-edge detector.
// The edge output is held off until every stage carries a real post-reset
// sample, so a line that is already low when reset releases is not an edge.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s_d;
  logic [SYNC_STAGES:0]   live_q;

  // Shift the line through the synchroniser and track which stages hold live data.
  // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain really is a chain.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '1;
      rx_s_d <= 1'b1;
      live_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_s_d <= sync_q[SYNC_STAGES-1];
      live_q <= {live_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = live_q[SYNC_STAGES] & rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start detection, mid-bit sampling of data, optional
// parity and 1/2 stop bits, and a one-entry holding register with overrun.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic             rx,
  output logic             overrun,
  output logic             busy,
  uart_rx_core_if.master   rx_bus
);

  localparam int BIT_W = $clog2(DATA_W);

  uart_rx_state_t    state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              deliver_q, deliver_d;
  logic              rx_s;
  logic              fall;
  logic              strobe;
  logic [DIV_W-1:0]  eff_div;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .rx     (rx),
    .rx_s   (rx_s),
    .fall   (fall)
  );

  assign eff_div = (baud_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : baud_div;
  assign strobe  = (cnt_q == '0);
  assign busy    = (state_q != RX_IDLE);

  // FSM, bit timer and frame datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      deliver_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      deliver_q <= deliver_d;
    end
  end

  // Next-state and datapath updates; each sample strobe advances one frame bit.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = strobe ? eff_div - 1'b1 : cnt_q - 1'b1;
    bit_d     = bit_q;
    sh_d      = sh_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    deliver_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (en && fall) begin
          // Half a bit to land the first strobe in the middle of the start bit.
          state_d = RX_START;
          cnt_d   = (eff_div >> 1) - 1'b1;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      RX_START: begin
        if (strobe) state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (strobe) begin
          sh_d  = {rx_s, sh_q[DATA_W-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_W'(DATA_W - 1)) state_d = parity_en ? RX_PARITY : RX_STOP1;
        end
      end
      RX_PARITY: begin
        if (strobe) begin
          perr_d  = ((^sh_q) ^ rx_s) != parity_odd;
          state_d = RX_STOP1;
        end
      end
      RX_STOP1: begin
        if (strobe) begin
          ferr_d = ferr_q | ~rx_s;
          if (stop2) begin
            state_d = RX_STOP2;
          end else begin
            deliver_d = 1'b1;
            state_d   = rx_s ? RX_IDLE : RX_WAIT_HI;
          end
        end
      end
      RX_STOP2: begin
        if (strobe) begin
          ferr_d    = ferr_q | ~rx_s;
          deliver_d = 1'b1;
          state_d   = rx_s ? RX_IDLE : RX_WAIT_HI;
        end
      end
      RX_WAIT_HI: begin
        // A low stop bit means break or framing loss: wait for the line to recover.
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
    if (!en) begin
      state_d   = RX_IDLE;
      deliver_d = 1'b0;
    end
  end

  // Holding register: accept a finished frame if empty or being read, else flag overrun.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_bus.rx_data  <= '0;
      rx_bus.rx_perr  <= 1'b0;
      rx_bus.rx_ferr  <= 1'b0;
      rx_bus.rx_valid <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver_q) begin
        if (!rx_bus.rx_valid || rx_bus.rx_ready) begin
          rx_bus.rx_data  <= sh_q;
          rx_bus.rx_perr  <= perr_q;
          rx_bus.rx_ferr  <= ferr_q;
          rx_bus.rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_bus.rx_valid && rx_bus.rx_ready) begin
        rx_bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed scenarios plus randomized frames, with a
// scoreboard of expected bytes checked by an independent monitor.
module tb_uart_rx_core;

  localparam int DATA_W      = 8;
  localparam int DIV_W       = 16;
  localparam int SYNC_STAGES = 2;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic             clk = 1'b0;
  logic             resetn;
  logic             en;
  logic [DIV_W-1:0] baud_div;
  logic             parity_en;
  logic             parity_odd;
  logic             stop2;
  logic             rx;
  logic             overrun;
  logic             busy;

  int   total  = 0;
  int   bad    = 0;
  int   exp_ov = 0;
  int   ov_seen = 0;
  exp_t sb[$];

  uart_rx_core_if #(.DATA_W(DATA_W)) bus ();

  uart_rx_core #(
    .DATA_W      (DATA_W),
    .DIV_W       (DIV_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .rx         (rx),
    .overrun    (overrun),
    .busy       (busy),
    .rx_bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic int eff();
    return (baud_div < 4) ? 4 : int'(baud_div);
  endfunction

  // Reference: what the receiver must report for a frame with these wire bits.
  function automatic exp_t model(input logic [7:0] d, input logic pb, input logic s1, input logic s2b);
    exp_t e;
    e.data = d;
    e.perr = parity_en && ((($countones(d) + int'(pb)) % 2) != int'(parity_odd));
    e.ferr = !s1 || (stop2 && !s2b);
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(eff());
  endtask

  task automatic go_idle(input int nbits);
    rx = 1'b1;
    tick(nbits * eff());
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic s1, input logic s2b,
                            input bit push, input bit chk_busy);
    logic last;
    if (push) sb.push_back(model(d, pb, s1, s2b));
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (parity_en) drive_bit(pb);
    if (stop2) begin
      drive_bit(s1);
      last = s2b;
    end else begin
      last = s1;
    end
    rx = last;
    if (chk_busy) begin
      tick(eff() / 2 + 4);
      check("busy_after_stop", {31'b0, busy}, 32'd0);
      tick(eff() - eff() / 2 - 4);
    end else begin
      tick(eff());
    end
  endtask

  // Monitor: every byte the consumer takes must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (overrun) ov_seen++;
      if (bus.rx_valid && bus.rx_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got=%0h want=none", bus.rx_data);
        end else begin
          e = sb.pop_front();
          check("rx_data", {24'b0, bus.rx_data}, {24'b0, e.data});
          check("rx_perr", {31'b0, bus.rx_perr}, {31'b0, e.perr});
          check("rx_ferr", {31'b0, bus.rx_ferr}, {31'b0, e.ferr});
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       pb, s1, s2b;

    resetn = 1'b0; en = 1'b0; rx = 1'b1; baud_div = 16;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; bus.rx_ready = 1'b1;
    tick(3);
    check("rst_data",  {24'b0, bus.rx_data}, 32'd0);
    check("rst_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("rst_flags", {30'b0, bus.rx_perr, bus.rx_ferr}, 32'd0);
    check("rst_ov",    {31'b0, overrun}, 32'd0);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    resetn = 1'b1; en = 1'b1;
    tick(5);

    // 8N1 0x55 with busy timing after the stop mid-bit.
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    go_idle(2);

    // Even parity, wrong then right parity bit.
    baud_div = 10; parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    go_idle(2);
    send_frame(8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    go_idle(2);

    // Break: low stop bit, line held low for 50 bits, then a normal frame.
    baud_div = 16; parity_en = 1'b0;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(50 * eff());
    check("busy_in_break", {31'b0, busy}, 32'd1);
    go_idle(3);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    go_idle(2);

    // Glitch shorter than half a bit.
    rx = 1'b0;
    tick(4);
    check("busy_in_glitch", {31'b0, busy}, 32'd1);
    rx = 1'b1;
    tick(10);
    check("busy_after_glitch", {31'b0, busy}, 32'd0);
    go_idle(2);

    // Overrun: second frame dropped while the first is unread.
    bus.rx_ready = 1'b0;
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    go_idle(2);
    send_frame(8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_ov++;
    go_idle(2);
    check("ovr_held_data",  {24'b0, bus.rx_data}, 32'h12);
    check("ovr_held_valid", {31'b0, bus.rx_valid}, 32'd1);
    bus.rx_ready = 1'b1;
    tick(1);
    check("valid_drop", {31'b0, bus.rx_valid}, 32'd0);

    // Reset during data bit 3 of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    tick(eff() / 2);
    resetn = 1'b0;
    tick(2);
    check("midrst_data",  {24'b0, bus.rx_data}, 32'd0);
    check("midrst_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("midrst_busy",  {31'b0, busy}, 32'd0);
    resetn = 1'b1;
    go_idle(7);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    go_idle(2);

    // Enable dropped during data bit 3 of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    tick(eff() / 2);
    en = 1'b0;
    tick(2);
    check("en_off_busy", {31'b0, busy}, 32'd0);
    en = 1'b1;
    go_idle(7);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    go_idle(2);

    // Reset released while the line is already low: no frame may start.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(3 * eff());
    check("busy_low_line", {31'b0, busy}, 32'd0);
    go_idle(2);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    go_idle(2);

    // Randomized frames across divider, parity and stop configurations.
    for (int n = 0; n < 40; n++) begin
      baud_div   = DIV_W'($urandom_range(0, 20));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      stop2      = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      pb  = (parity_odd ? ~^d : ^d) ^ ($urandom_range(0, 3) == 0);
      s1  = ($urandom_range(0, 4) != 0);
      s2b = ($urandom_range(0, 4) != 0);
      send_frame(d, pb, s1, s2b, 1'b1, 1'b0);
      go_idle(2);
    end

    for (int i = 0; i < 2000 && sb.size() != 0; i++) tick(1);
    check("sb_drained", sb.size(), 32'd0);
    check("overrun_count", ov_seen, exp_ov);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
